multi_way_switch: RTL
=====================

MULTI_WAY_SWITCH -- requirements
Module: multi_way_switch

Interface
REQ-001 Parameter N_SW, default 3: number of switch channels; legal range 2..16.
REQ-002 Parameter DEB_CYC, default 4: debounce length in clock cycles; legal range 1..255.
REQ-003 Parameter AUTO_OFF_CYC, default 1000: auto-off timeout in cycles; legal range 1..2^20-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 x  input  N_SW  raw asynchronous switch levels; x[0] is switch 1.
REQ-007 f  output  1  registered lamp output.
REQ-008 chg  output  1  one-cycle pulse in the cycle after f changes value.
REQ-009 stable  output  N_SW  debounced switch levels, registered.
REQ-010 auto_off  output  1  one-cycle pulse when the timer forces f to 0.

Function
REQ-011 Each x bit shall pass through a 2-flop synchroniser before any other logic.
REQ-012 stable[i] shall take the synchronised level only after that level differs from stable[i] for DEB_CYC consecutive cycles; any cycle of agreement shall clear channel i's counter to 0.
REQ-013 A clean level change on x[i] shall appear on stable[i] exactly DEB_CYC+2 rising edges after the first edge sampling the new level.
REQ-014 A glitch shorter than DEB_CYC synchronised cycles shall never change stable or f.
REQ-015 An update shall be the cycle in which stable[i] changes; f_next = f XOR (parity of all channel updates in that cycle).
REQ-016 Simultaneous updates on an even number of channels shall leave f unchanged with no chg pulse; an odd number shall toggle f once.
REQ-017 chg shall be 1 for exactly one cycle per change of f, whatever the cause of the change.
REQ-018 Steady-state relation: with the auto-off timer never expiring, f shall equal the XOR of all stable bits.
REQ-019 Debounce counters shall saturate at DEB_CYC and shall never wrap.

Reset
REQ-020 While rst_n=0 at a clock edge: synchronisers, stable, counters, f, chg, auto_off and the timer shall all be 0.
REQ-021 Any x bit held at 1 through reset release shall update stable DEB_CYC+2 edges after release, and f shall follow the update.
REQ-022 Reset asserted mid-debounce or mid-timeout shall discard all progress with no chg or auto_off pulse.

Configuration
REQ-023 Macro MULTI_WAY_AUTO_OFF_EN shall compile the auto-off timer in or out.
REQ-024 With the macro defined: the timer counts cycles while f=1, clears on any change of f, and on reaching AUTO_OFF_CYC forces f to 0 and pulses chg and auto_off together.
REQ-025 With the macro defined: if a toggling update coincides with expiry, f goes 0 with one chg pulse and auto_off stays 0, so the switch takes priority.
REQ-026 Without the macro: auto_off shall be tied 0, no timer logic shall exist, and REQ-018 always holds.

Structure
REQ-027 Package multi_way_pkg shall hold the default N_SW, DEB_CYC and AUTO_OFF_CYC constants and the timer width constant (20).
REQ-028 Sub-module sw_debounce (synchroniser, counter and stable flop for one channel) shall be instantiated N_SW times through a generate loop.

Verification
REQ-029 N_SW=3, DEB_CYC=4: walk x through 000..111 in Gray order, 20 cycles per step -> f toggles on each step; each toggle occurs 6 edges after the change, with one chg pulse each.
REQ-030 x[1] pulses high for 3 cycles -> stable and f unchanged; chg remains 0.
REQ-031 x[0] and x[2] rise on the same edge -> both stable bits update in the same cycle; f unchanged; chg 0.
REQ-032 x=3'b001 through reset release -> stable=001 and f=1 at release+6 edges.
REQ-033 Macro defined, AUTO_OFF_CYC=10: f=1 held -> at timeout f=0, chg=1 and auto_off=1 for one cycle. Then a toggling update on the expiry cycle -> f=0, chg=1, auto_off=0.
REQ-034 rst_n=0 asserted 2 cycles into a debounce -> all outputs 0 on the next edge, and no pulse after release.

Source files
------------

// File: rtl/multi_way_pkg.sv
// Shared constants for the multi-way lamp switch: default channel count,
// debounce length, auto-off timeout and counter widths.
package multi_way_pkg;

  localparam int N_SW_DEF         = 3;
  localparam int DEB_CYC_DEF      = 4;
  localparam int AUTO_OFF_CYC_DEF = 1000;
  localparam int TMR_W            = 20;
  localparam int DEB_CNT_W        = 8;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, saturating debounce counter and
// the debounced level, plus a strobe marking the cycle the level changes.
module sw_debounce
  import multi_way_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_i,
  output logic stable_o,
  output logic upd_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_LIM = DEB_CNT_W'(DEB_CYC);

  logic                 meta_q, sync_q;
  logic                 stable_q, stable_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // Counter restarts on any cycle of agreement and on the cycle it commits.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    cnt_inc  = (cnt_q == DEB_LIM) ? cnt_q : cnt_q + DEB_CNT_W'(1);
    if (sync_q != stable_q) begin
      if (cnt_inc == DEB_LIM) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= x_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = stable_d ^ stable_q;

endmodule

// File: rtl/multi_way_switch.sv
// Multi-way lamp switch: any debounced switch flip toggles the lamp.
// Define MULTI_WAY_AUTO_OFF_EN to build in the auto-off timer.
module multi_way_switch
  import multi_way_pkg::*;
#(
  parameter int N_SW         = N_SW_DEF,
  parameter int DEB_CYC      = DEB_CYC_DEF,
  parameter int AUTO_OFF_CYC = AUTO_OFF_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] x,
  output logic            f,
  output logic            chg,
  output logic [N_SW-1:0] stable,
  output logic            auto_off
);

  if (N_SW < 2 || N_SW > 16 || DEB_CYC < 1 || DEB_CYC > 255 ||
      AUTO_OFF_CYC < 1 || AUTO_OFF_CYC > (1 << TMR_W) - 1) begin : g_bad_param
    $error("multi_way_switch: parameter out of legal range");
  end

  logic [N_SW-1:0] upd;
  logic            tgl;
  logic            f_q, f_d, chg_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .x_i      (x[i]),
      .stable_o (stable[i]),
      .upd_o    (upd[i])
    );
  end

  // An even number of simultaneous flips cancels out.
  assign tgl = ^upd;

`ifdef MULTI_WAY_AUTO_OFF_EN
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_OFF_CYC - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             ao_q, ao_d;

  // A switch toggle wins over a coincident expiry and suppresses auto_off.
  always_comb begin
    f_d   = f_q;
    ao_d  = 1'b0;
    tmr_d = '0;
    if (tgl) begin
      f_d = ~f_q;
    end else if (f_q && tmr_q == TMR_LAST) begin
      f_d  = 1'b0;
      ao_d = 1'b1;
    end
    if (f_q && f_d == f_q) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q <= '0;
      ao_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      ao_q  <= ao_d;
    end
  end

  assign auto_off = ao_q;
`else
  always_comb begin
    f_d = f_q ^ tgl;
  end

  assign auto_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q   <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      f_q   <= f_d;
      chg_q <= f_d ^ f_q;
    end
  end

  assign f   = f_q;
  assign chg = chg_q;

endmodule
